// File: rtl/bc_pkg.sv
// bc_pkg -- shared definitions for the Horner evaluator controller.
//   state_t     : FSM state enumeration and its encoding
//   M0_*/M1_*   : ALU operand-A / operand-B select codes
//   M2_*        : H register input select codes
//   OP_*        : ALU operation codes driven on output H
package bc_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_INIT = 3'd1,
      S_MUL  = 3'd2,
      S_ADD  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   // operand-A select
   localparam logic [1:0] M0_ZERO = 2'b00;
   localparam logic [1:0] M0_H    = 2'b01;
   localparam logic [1:0] M0_L    = 2'b10;

   // operand-B select
   localparam logic [1:0] M1_ZERO = 2'b00;
   localparam logic [1:0] M1_COEF = 2'b01;
   localparam logic [1:0] M1_X    = 2'b10;

   // H register input select
   localparam logic [1:0] M2_ALU  = 2'b00;
   localparam logic [1:0] M2_COEF = 2'b01;

   // ALU operation
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_MUL = 1'b1;

endpackage

// File: rtl/bc_contador.sv
// bc_contador -- coefficient index down-counter.
//   clk, rst  : clock, asynchronous active-high reset (idx clears to 0)
//   load      : load load_val into idx
//   dec       : decrement idx; ignored when idx is already 0 (never wraps)
//   load_val  : value loaded on load
//   idx       : current index
//   zero      : idx == 0
module bc_contador #(
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             dec,
   input  logic [IDX_W-1:0] load_val,
   output logic [IDX_W-1:0] idx,
   output logic             zero
);

   assign zero = (idx == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx <= '0;
      end else if (load) begin
         idx <= load_val;
      end else if (dec && !zero) begin
         idx <= idx - 1'b1;
      end
   end

endmodule

// File: rtl/bc_horner.sv
// bc_horner -- Moore controller sequencing Horner evaluation of a
// degree-DEGREE polynomial on an external X/H/L register + ALU datapath.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : run request (level); holding it keeps the FSM in DONE
//   abort     : cancel a run; returns to IDLE on the next edge
//   LX/LH/LL  : load enables for X, H, L registers
//   M0/M1/M2  : operand-A, operand-B, H-input selects
//   H         : ALU operation (1 multiply, 0 add)
//   coef_idx  : coefficient index for the coefficient mux
//   busy      : run in progress (INIT/MUL/ADD)
//   pronto    : result valid in H register (DONE)
module bc_horner
   import bc_pkg::*;
#(
   parameter int DEGREE = 3,
   parameter int IDX_W  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   output logic             LX,
   output logic             LH,
   output logic             LL,
   output logic [1:0]       M0,
   output logic [1:0]       M1,
   output logic [1:0]       M2,
   output logic             H,
   output logic [IDX_W-1:0] coef_idx,
   output logic             busy,
   output logic             pronto
);

   state_t           state;
   state_t           state_nxt;
   logic [IDX_W-1:0] idx;
   logic             idx_zero;
   logic             idx_load;
   logic             idx_dec;

   // An aborted cycle must leave idx untouched, so both controls are gated.
   assign idx_load = (state == S_INIT) && !abort;
   assign idx_dec  = (state == S_ADD)  && !abort;

   bc_contador #(
      .IDX_W (IDX_W)
   ) u_contador (
      .clk      (clk),
      .rst      (rst),
      .load     (idx_load),
      .dec      (idx_dec),
      .load_val (IDX_W'(DEGREE - 1)),
      .idx      (idx),
      .zero     (idx_zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (start && !abort) state_nxt = S_INIT;
         S_INIT: state_nxt = abort ? S_IDLE : S_MUL;
         S_MUL:  state_nxt = abort ? S_IDLE : S_ADD;
         S_ADD: begin
            if (abort)         state_nxt = S_IDLE;
            else if (idx_zero) state_nxt = S_DONE;
            else               state_nxt = S_MUL;
         end
         S_DONE: if (abort || !start) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      LX       = 1'b0;
      LH       = 1'b0;
      LL       = 1'b0;
      M0       = M0_ZERO;
      M1       = M1_ZERO;
      M2       = M2_ALU;
      H        = OP_ADD;
      coef_idx = '0;
      busy     = 1'b0;
      pronto   = 1'b0;
      case (state)
         S_IDLE: LX = 1'b1;
         S_INIT: begin
            M2       = M2_COEF;
            LH       = 1'b1;
            coef_idx = IDX_W'(DEGREE);
            busy     = 1'b1;
         end
         S_MUL: begin
            M0   = M0_H;
            M1   = M1_X;
            H    = OP_MUL;
            LL   = 1'b1;
            busy = 1'b1;
         end
         S_ADD: begin
            M0       = M0_L;
            M1       = M1_COEF;
            M2       = M2_ALU;
            H        = OP_ADD;
            LH       = 1'b1;
            coef_idx = idx;
            busy     = 1'b1;
         end
         S_DONE: pronto = 1'b1;
         default: LX = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_bc_horner.sv
// tb_bc_horner -- directed self-checking bench for bc_horner.
// u3 runs with DEGREE=3, u1 with DEGREE=1; both default IDX_W=4.
// Step convention: inputs change just after an edge ("edge 0") and
// outputs are sampled 1 ns after each following edge (edges 1, 2, ...).
module tb_bc_horner;

   localparam int ST_IDLE = 0;
   localparam int ST_INIT = 1;
   localparam int ST_MUL  = 2;
   localparam int ST_ADD  = 3;
   localparam int ST_DONE = 4;

   logic clk;
   logic rst;
   logic start3, abort3, start1, abort1;

   logic       lx3, lh3, ll3, h3, busy3, pronto3;
   logic [1:0] m0_3, m1_3, m2_3;
   logic [3:0] ci3;
   logic       lx1, lh1, ll1, h1, busy1, pronto1;
   logic [1:0] m0_1, m1_1, m2_1;
   logic [3:0] ci1;

   int npass;
   int ntot;
   int lhc, llc, prc;

   bc_horner #(.DEGREE(3), .IDX_W(4)) u3 (
      .clk(clk), .rst(rst), .start(start3), .abort(abort3),
      .LX(lx3), .LH(lh3), .LL(ll3), .M0(m0_3), .M1(m1_3), .M2(m2_3),
      .H(h3), .coef_idx(ci3), .busy(busy3), .pronto(pronto3)
   );

   bc_horner #(.DEGREE(1), .IDX_W(4)) u1 (
      .clk(clk), .rst(rst), .start(start1), .abort(abort1),
      .LX(lx1), .LH(lh1), .LL(ll1), .M0(m0_1), .M1(m1_1), .M2(m2_1),
      .H(h1), .coef_idx(ci1), .busy(busy1), .pronto(pronto1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {LX,LH,LL,M0,M1,M2,H,coef_idx,busy,pronto}
   function automatic logic [15:0] exp_vec(input int s, input int ci);
      logic [3:0] c;
      c = 4'(ci);
      case (s)
         ST_IDLE: exp_vec = {3'b100, 2'b00, 2'b00, 2'b00, 1'b0, 4'd0, 1'b0, 1'b0};
         ST_INIT: exp_vec = {3'b010, 2'b00, 2'b00, 2'b01, 1'b0, c,    1'b1, 1'b0};
         ST_MUL:  exp_vec = {3'b001, 2'b01, 2'b10, 2'b00, 1'b1, 4'd0, 1'b1, 1'b0};
         ST_ADD:  exp_vec = {3'b010, 2'b10, 2'b01, 2'b00, 1'b0, c,    1'b1, 1'b0};
         default: exp_vec = {3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 4'd0, 1'b0, 1'b1};
      endcase
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %04h expected %04h", tag, obs, exp);
   endtask

   task automatic chk3(input string tag, input int s, input int ci);
      chk(tag, {lx3, lh3, ll3, m0_3, m1_3, m2_3, h3, ci3, busy3, pronto3}, exp_vec(s, ci));
   endtask

   task automatic chk1(input string tag, input int s, input int ci);
      chk(tag, {lx1, lh1, ll1, m0_1, m1_1, m2_1, h1, ci1, busy1, pronto1}, exp_vec(s, ci));
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic step3(input string tag, input int s, input int ci);
      tick();
      lhc += int'(lh3);
      llc += int'(ll3);
      prc += int'(pronto3);
      chk3(tag, s, ci);
   endtask

   task automatic step1(input string tag, input int s, input int ci);
      tick();
      chk1(tag, s, ci);
   endtask

   initial begin
      npass = 0; ntot = 0; lhc = 0; llc = 0; prc = 0;
      rst = 1'b1; start3 = 1'b0; abort3 = 1'b0; start1 = 1'b0; abort1 = 1'b0;

      // reset state
      tick();
      chk3("rst_d3", ST_IDLE, 0);
      chk1("rst_d1", ST_IDLE, 0);
      rst = 1'b0;
      step3("idle_after_rst", ST_IDLE, 0);

      // single-cycle start pulse, DEGREE=3
      lhc = 0; llc = 0;
      start3 = 1'b1;
      step3("run_e1_init", ST_INIT, 3);
      start3 = 1'b0;
      step3("run_e2_mul",  ST_MUL, 0);
      step3("run_e3_add2", ST_ADD, 2);
      step3("run_e4_mul",  ST_MUL, 0);
      step3("run_e5_add1", ST_ADD, 1);
      step3("run_e6_mul",  ST_MUL, 0);
      step3("run_e7_add0", ST_ADD, 0);
      step3("run_e8_done", ST_DONE, 0);
      chk("lh_count", 16'(lhc), 16'd4);
      chk("ll_count", 16'(llc), 16'd3);
      step3("run_e9_idle", ST_IDLE, 0);

      // start held through DONE
      start3 = 1'b1;
      step3("hold_init", ST_INIT, 3);
      step3("hold_mul",  ST_MUL, 0);
      step3("hold_add2", ST_ADD, 2);
      step3("hold_mul2", ST_MUL, 0);
      step3("hold_add1", ST_ADD, 1);
      step3("hold_mul3", ST_MUL, 0);
      step3("hold_add0", ST_ADD, 0);
      step3("hold_done", ST_DONE, 0);
      for (int i = 0; i < 5; i++) step3("hold_done_stay", ST_DONE, 0);
      start3 = 1'b0;
      step3("hold_release_idle", ST_IDLE, 0);

      // abort in second MUL, then a full run
      prc = 0;
      start3 = 1'b1;
      step3("ab_init", ST_INIT, 3);
      start3 = 1'b0;
      step3("ab_mul1", ST_MUL, 0);
      step3("ab_add2", ST_ADD, 2);
      step3("ab_mul2", ST_MUL, 0);
      abort3 = 1'b1;
      step3("ab_idle", ST_IDLE, 0);
      abort3 = 1'b0;
      chk("ab_no_pronto", 16'(prc), 16'd0);
      start3 = 1'b1;
      step3("ab_rerun_init", ST_INIT, 3);
      start3 = 1'b0;
      step3("ab_rerun_mul",  ST_MUL, 0);
      step3("ab_rerun_add2", ST_ADD, 2);
      step3("ab_rerun_mul2", ST_MUL, 0);
      step3("ab_rerun_add1", ST_ADD, 1);
      step3("ab_rerun_mul3", ST_MUL, 0);
      step3("ab_rerun_add0", ST_ADD, 0);
      step3("ab_rerun_e8_done", ST_DONE, 0);
      step3("ab_rerun_idle", ST_IDLE, 0);

      // start and abort together in IDLE; start again while busy
      start3 = 1'b1; abort3 = 1'b1;
      step3("sa_idle1", ST_IDLE, 0);
      step3("sa_idle2", ST_IDLE, 0);
      abort3 = 1'b0;
      step3("sb_init", ST_INIT, 3);
      start3 = 1'b0;
      step3("sb_mul",  ST_MUL, 0);
      step3("sb_add2", ST_ADD, 2);
      start3 = 1'b1;
      step3("sb_mul2", ST_MUL, 0);
      start3 = 1'b0;
      step3("sb_add1", ST_ADD, 1);
      step3("sb_mul3", ST_MUL, 0);
      step3("sb_add0", ST_ADD, 0);
      step3("sb_e8_done", ST_DONE, 0);
      step3("sb_idle", ST_IDLE, 0);

      // asynchronous reset mid-MUL
      start3 = 1'b1;
      step3("rm_init", ST_INIT, 3);
      start3 = 1'b0;
      step3("rm_mul", ST_MUL, 0);
      #2 rst = 1'b1;
      #1 chk3("rm_async_idle", ST_IDLE, 0);
      tick();
      chk3("rm_held_idle", ST_IDLE, 0);
      rst = 1'b0;
      step3("rm_after_release", ST_IDLE, 0);

      // DEGREE=1 sequence
      start1 = 1'b1;
      step1("d1_e1_init", ST_INIT, 1);
      start1 = 1'b0;
      step1("d1_e2_mul",  ST_MUL, 0);
      step1("d1_e3_add0", ST_ADD, 0);
      step1("d1_e4_done", ST_DONE, 0);
      step1("d1_e5_idle", ST_IDLE, 0);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
